player_sprite_engine: RTL and testbench

// Multi-player sprite renderer for the kitchen display. Draws NUM_PLAYERS animated chef sprites with

---
 rtl/player_sprite_engine_pkg.sv | 63 ++++++
 rtl/player_sprite_engine_anim_ctrl.sv | 53 +++++
 rtl/player_sprite_engine.sv | 160 ++++++++++++++++
 tb/tb_player_sprite_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_sprite_engine_pkg.sv
// Shared types, default transparent index and the ROM content helpers for the player sprite engine.
package player_sprite_engine_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        ST_NOTHING        = 4'd0,
        ST_ONION_RAW      = 4'd1,
        ST_ONION_CHOPPED  = 4'd2,
        ST_TOMATO_RAW     = 4'd3,
        ST_TOMATO_CHOPPED = 4'd4,
        ST_POT_RAW        = 4'd5,
        ST_POT_COOKED     = 4'd6,
        ST_PLATE_EMPTY    = 4'd7,
        ST_PLATE_FULL     = 4'd8,
        ST_EXT_OFF        = 4'd9,
        ST_EXT_ON         = 4'd10
    } pstate_t;

    localparam logic [7:0] TRANSP_IDX_DEFAULT = 8'h00;

    // Back view hides the held item; raw pot shares the cooked pot art; undefined states draw empty-handed.
    function automatic logic [5:0] sprite_idx(input logic [3:0] state, input logic [1:0] dir);
        logic [3:0] art;
        if (dir == DIR_UP)
            art = ST_NOTHING;
        else if (state > ST_EXT_ON)
            art = ST_NOTHING;
        else if (state == ST_POT_RAW)
            art = ST_POT_COOKED;
        else
            art = state;
        return {art, dir};
    endfunction

    function automatic logic [7:0] atlas_pixel(input logic [5:0] sidx, input logic [7:0] frame,
                                               input logic [7:0] row, input logic [7:0] col);
        logic [7:0] v;
        if (((row + col + frame) & 8'd3) == 8'd0)
            v = 8'h00;
        else
            v = {2'b00, sidx} * 8'd7 + frame * 8'd13 + row * 8'd3 + col;
        return v;
    endfunction

    function automatic logic [3:0] pal_red(input logic [7:0] idx);
        return idx[7:4];
    endfunction

    function automatic logic [3:0] pal_green(input logic [7:0] idx);
        return idx[3:0];
    endfunction

    function automatic logic [3:0] pal_blue(input logic [7:0] idx);
        return idx[7:4] ^ idx[3:0];
    endfunction

endpackage

// File: rtl/player_sprite_engine_anim_ctrl.sv
// Per-player shadow registers latched once per video frame, plus the animation tick/frame counters.
module player_sprite_engine_anim_ctrl #(
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 8,
    localparam int FRM_W  = $clog2(NUM_FRAMES),
    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic [10:0]      x,
    input  logic [9:0]       y,
    input  logic [1:0]       dir,
    input  logic [3:0]       state,
    output logic [10:0]      sh_x,
    output logic [9:0]       sh_y,
    output logic [1:0]       sh_dir,
    output logic [3:0]       sh_state,
    output logic [FRM_W-1:0] frame,
    output logic             shadow_valid
);

    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x         <= '0;
            sh_y         <= '0;
            sh_dir       <= '0;
            sh_state     <= '0;
            frame        <= '0;
            tick_cnt     <= '0;
            shadow_valid <= 1'b0;
        end else if (frame_tick) begin
            sh_x         <= x;
            sh_y         <= y;
            sh_dir       <= dir;
            sh_state     <= state;
            shadow_valid <= 1'b1;
            // A new pose restarts its animation from the first frame.
            if (dir != sh_dir || state != sh_state) begin
                frame    <= '0;
                tick_cnt <= '0;
            end else if (tick_cnt == TICK_W'(FRAME_TICKS - 1)) begin
                frame    <= frame + FRM_W'(1);
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/player_sprite_engine.sv
// Multi-player chef sprite renderer: per-player atlas lookup, fixed-priority transparency mux,
// shared palette, five-cycle pipeline from raster position to colour.
module player_sprite_engine
    import player_sprite_engine_pkg::*;
#(
    parameter int         NUM_PLAYERS = 2,
    parameter int         WIDTH       = 32,
    parameter int         HEIGHT      = 32,
    parameter int         NUM_FRAMES  = 4,
    parameter int         FRAME_TICKS = 8,
    parameter logic [7:0] TRANSP_IDX  = TRANSP_IDX_DEFAULT
) (
    input  logic                      pixel_clk_in,
    input  logic                      rst_n_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic [NUM_PLAYERS*11-1:0] x_in,
    input  logic [NUM_PLAYERS*10-1:0] y_in,
    input  logic [NUM_PLAYERS*2-1:0]  dir_in,
    input  logic [NUM_PLAYERS*4-1:0]  state_in,
    output logic [11:0]               pixel_out,
    output logic                      hit_out,
    output logic [1:0]                player_id_out
);

    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int FRM_W  = $clog2(NUM_FRAMES);
    localparam int ADDR_W = 6 + FRM_W + ROW_W + COL_W;

    logic                   frame_tick;
    logic [NUM_PLAYERS-1:0] inside_p2;
    logic [7:0]             atlas_p2 [NUM_PLAYERS];

    assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [10:0]       sh_x;
        logic [9:0]        sh_y;
        logic [1:0]        sh_dir;
        logic [3:0]        sh_state;
        logic [FRM_W-1:0]  frame;
        logic              shadow_valid;
        logic [11:0]       x_end;
        logic [10:0]       y_end;
        logic              inside_d;
        logic [ADDR_W-1:0] addr_d;
        logic              inside_p1;
        logic [ADDR_W-1:0] addr_p1;
        logic              inside_rd_p2;
        logic [7:0]        atlas_rd_p2;

        player_sprite_engine_anim_ctrl #(
            .NUM_FRAMES  (NUM_FRAMES),
            .FRAME_TICKS (FRAME_TICKS)
        ) u_anim (
            .clk          (pixel_clk_in),
            .rst_n        (rst_n_in),
            .frame_tick   (frame_tick),
            .x            (x_in[p*11 +: 11]),
            .y            (y_in[p*10 +: 10]),
            .dir          (dir_in[p*2 +: 2]),
            .state        (state_in[p*4 +: 4]),
            .sh_x         (sh_x),
            .sh_y         (sh_y),
            .sh_dir       (sh_dir),
            .sh_state     (sh_state),
            .frame        (frame),
            .shadow_valid (shadow_valid)
        );

        // Widened end coordinates keep sprites at the right/bottom edge from wrapping to 0.
        assign x_end    = {1'b0, sh_x} + 12'(WIDTH);
        assign y_end    = {1'b0, sh_y} + 11'(HEIGHT);
        assign inside_d = shadow_valid
                          && (hcount_in >= sh_x) && ({1'b0, hcount_in} < x_end)
                          && (vcount_in >= sh_y) && ({1'b0, vcount_in} < y_end);
        assign addr_d   = {sprite_idx(sh_state, sh_dir), frame,
                           vcount_in[ROW_W-1:0] - sh_y[ROW_W-1:0],
                           hcount_in[COL_W-1:0] - sh_x[COL_W-1:0]};

        // S1: address and inside flag; S2: synchronous atlas read
        always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                addr_p1      <= '0;
                inside_p1    <= 1'b0;
                atlas_rd_p2  <= '0;
                inside_rd_p2 <= 1'b0;
            end else begin
                addr_p1      <= addr_d;
                inside_p1    <= inside_d;
                atlas_rd_p2  <= atlas_pixel(addr_p1[ADDR_W-1 -: 6],
                                            8'(addr_p1[COL_W+ROW_W +: FRM_W]),
                                            8'(addr_p1[COL_W +: ROW_W]),
                                            8'(addr_p1[0 +: COL_W]));
                inside_rd_p2 <= inside_p1;
            end
        end

        assign atlas_p2[p]  = atlas_rd_p2;
        assign inside_p2[p] = inside_rd_p2;
    end

    logic [7:0] win_idx;
    logic [1:0] win_id;
    logic       win_hit;

    // Walk from the lowest priority upward so the lowest-numbered opaque player overrides.
    always_comb begin
        win_idx = TRANSP_IDX;
        win_id  = '0;
        win_hit = 1'b0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (inside_p2[p] && atlas_p2[p] != TRANSP_IDX) begin
                win_idx = atlas_p2[p];
                win_id  = 2'(p);
                win_hit = 1'b1;
            end
        end
    end

    logic [7:0] win_idx_p3;
    logic [1:0] win_id_p3;
    logic       hit_p3;
    logic [3:0] red_p4;
    logic [3:0] green_p4;
    logic [3:0] blue_p4;
    logic [1:0] id_p4;
    logic       hit_p4;

    // S3: winner; S4: palette read; S5: output register
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            win_idx_p3    <= '0;
            win_id_p3     <= '0;
            hit_p3        <= 1'b0;
            red_p4        <= '0;
            green_p4      <= '0;
            blue_p4       <= '0;
            id_p4         <= '0;
            hit_p4        <= 1'b0;
            pixel_out     <= '0;
            hit_out       <= 1'b0;
            player_id_out <= '0;
        end else begin
            win_idx_p3    <= win_idx;
            win_id_p3     <= win_id;
            hit_p3        <= win_hit;
            red_p4        <= pal_red(win_idx_p3);
            green_p4      <= pal_green(win_idx_p3);
            blue_p4       <= pal_blue(win_idx_p3);
            id_p4         <= win_id_p3;
            hit_p4        <= hit_p3;
            pixel_out     <= hit_p4 ? {red_p4, green_p4, blue_p4} : 12'h000;
            hit_out       <= hit_p4;
            player_id_out <= hit_p4 ? id_p4 : 2'd0;
        end
    end

endmodule

// File: tb/tb_player_sprite_engine.sv
// Randomized and directed bench for player_sprite_engine against a pixel-level reference model.
module tb_player_sprite_engine;

    localparam int NP = 2;
    localparam int FT = 2;
    localparam int NF = 4;
    localparam int W  = 32;
    localparam int H  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [10:0]   hcount = 11'd1;
    logic [9:0]    vcount = 10'd1;
    logic [NP*11-1:0] x_bus = '0;
    logic [NP*10-1:0] y_bus = '0;
    logic [NP*2-1:0]  dir_bus = '0;
    logic [NP*4-1:0]  state_bus = '0;
    logic [11:0]   pixel_out;
    logic          hit_out;
    logic [1:0]    player_id_out;

    player_sprite_engine #(
        .NUM_PLAYERS (NP),
        .WIDTH       (W),
        .HEIGHT      (H),
        .NUM_FRAMES  (NF),
        .FRAME_TICKS (FT),
        .TRANSP_IDX  (8'h00)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .x_in          (x_bus),
        .y_in          (y_bus),
        .dir_in        (dir_bus),
        .state_in      (state_bus),
        .pixel_out     (pixel_out),
        .hit_out       (hit_out),
        .player_id_out (player_id_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pix;
        logic        hit;
        logic [1:0]  id;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    string phase = "init";

    int m_valid [NP];
    int m_x     [NP];
    int m_y     [NP];
    int m_dir   [NP];
    int m_st    [NP];
    int m_frame [NP];
    int m_tick  [NP];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic int ref_sprite(input int st, input int d);
        int art;
        if (d == 2) return 2;
        art = st;
        if (art > 10) art = 0;
        if (art == 5) art = 6;
        return art * 4 + d;
    endfunction

    function automatic int ref_atlas(input int sidx, input int fr, input int row, input int col);
        if ((row + col + fr) % 4 == 0) return 0;
        return (sidx * 7 + fr * 13 + row * 3 + col) % 256;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_valid[p] = 0; m_x[p] = 0; m_y[p] = 0; m_dir[p] = 0;
            m_st[p] = 0; m_frame[p] = 0; m_tick[p] = 0;
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back('{pix: 12'h0, hit: 1'b0, id: 2'd0});
    endtask

    task automatic set_player(input int p, input int x, input int y, input int d, input int s);
        x_bus[p*11 +: 11]    = 11'(x);
        y_bus[p*10 +: 10]    = 10'(y);
        dir_bus[p*2 +: 2]    = 2'(d);
        state_bus[p*4 +: 4]  = 4'(s);
    endtask

    // One raster pixel: predict its output, advance the model, clock, and compare the pixel from 5 cycles ago.
    task automatic drive_px(input int h, input int v);
        exp_t e;
        exp_t old;
        int   hh, vv, idx, nd, ns;
        bit   done;
        hcount = 11'(h);
        vcount = 10'(v);
        hh = int'(hcount);
        vv = int'(vcount);
        e = '{pix: 12'h0, hit: 1'b0, id: 2'd0};
        done = 0;
        for (int p = 0; p < NP; p++) begin
            if (!done && m_valid[p] != 0 && hh >= m_x[p] && hh < m_x[p] + W
                && vv >= m_y[p] && vv < m_y[p] + H) begin
                idx = ref_atlas(ref_sprite(m_st[p], m_dir[p]), m_frame[p], vv - m_y[p], hh - m_x[p]);
                if (idx != 0) begin
                    done  = 1;
                    e.hit = 1'b1;
                    e.id  = 2'(p);
                    e.pix = 12'(((idx / 16) << 8) | ((idx % 16) << 4) | ((idx / 16) ^ (idx % 16)));
                end
            end
        end
        if (hh == 0 && vv == 0) begin
            for (int p = 0; p < NP; p++) begin
                nd = int'(dir_bus[p*2 +: 2]);
                ns = int'(state_bus[p*4 +: 4]);
                if (nd != m_dir[p] || ns != m_st[p]) begin
                    m_frame[p] = 0;
                    m_tick[p]  = 0;
                end else if (m_tick[p] == FT - 1) begin
                    m_tick[p]  = 0;
                    m_frame[p] = (m_frame[p] + 1) % NF;
                end else begin
                    m_tick[p]++;
                end
                m_x[p] = int'(x_bus[p*11 +: 11]);
                m_y[p] = int'(y_bus[p*10 +: 10]);
                m_dir[p] = nd;
                m_st[p] = ns;
                m_valid[p] = 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 5) begin
            old = exp_q.pop_front();
            check_val({phase, ".pix"}, 32'(pixel_out), 32'(old.pix));
            check_val({phase, ".hit"}, 32'(hit_out), 32'(old.hit));
            check_val({phase, ".id"}, 32'(player_id_out), 32'(old.id));
        end
    endtask

    task automatic do_reset(input string why);
        rst_n = 1'b0;
        #1;
        check_val({why, ".rst_pix"}, 32'(pixel_out), 32'h0);
        check_val({why, ".rst_hit"}, 32'(hit_out), 32'h0);
        check_val({why, ".rst_id"}, 32'(player_id_out), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val({why, ".hold_pix"}, 32'(pixel_out), 32'h0);
        check_val({why, ".hold_hit"}, 32'(hit_out), 32'h0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic first_frame_test();
        phase = "first";
        set_player(0, 100, 50, 3, 0);
        set_player(1, 2000, 1000, 0, 0);
        for (int v = 49; v <= 51; v++)
            for (int h = 95; h <= 140; h++) drive_px(h, v);
        drive_px(0, 0);
        for (int v = 50; v <= 52; v++)
            for (int h = 96; h <= 136; h++) drive_px(h, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset("por");
        first_frame_test();

        phase = "overlap";
        set_player(1, 200, 100, 1, 1);
        set_player(0, 200, 100, 3, 0);
        drive_px(0, 0);
        for (int h = 198; h <= 234; h++) drive_px(h, 101);
        drive_px(0, 0);
        drive_px(0, 0);
        set_player(0, 200, 100, 1, 0);
        drive_px(0, 0);
        drive_px(205, 103);
        drive_px(206, 103);
        for (int v = 100; v <= 106; v++)
            for (int h = 198; h <= 234; h++) drive_px(h, v);

        phase = "anim";
        set_player(0, 300, 200, 0, 7);
        set_player(1, 1500, 600, 0, 0);
        for (int t = 1; t <= 10; t++) begin
            if (t == 5) set_player(0, 300, 200, 0, 8);
            drive_px(0, 0);
            for (int i = 0; i < 12; i++)
                for (int h = 300; h < 332; h += 3) drive_px(h, 200 + i * 2);
        end

        phase = "clip";
        set_player(0, 1270, 710, 3, 0);
        set_player(1, 1275, 715, 1, 5);
        drive_px(0, 0);
        for (int v = 710; v <= 718; v++) begin
            for (int h = 1260; h <= 1279; h++) drive_px(h, v);
            for (int h = 0; h <= 25; h++) drive_px(h, v);
        end

        phase = "midframe";
        set_player(0, 400, 290, 3, 2);
        drive_px(0, 0);
        for (int h = 395; h <= 440; h++) drive_px(h, 300);
        set_player(0, 410, 290, 3, 2);
        for (int h = 395; h <= 445; h++) drive_px(h, 301);
        drive_px(0, 0);
        for (int h = 395; h <= 445; h++) drive_px(h, 302);

        phase = "random";
        for (int f = 0; f < 30; f++) begin
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 2) != 0)
                    set_player(p, int'($urandom_range(0, 1300)), int'($urandom_range(0, 730)),
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) set_player(1, m_x[0] + 5, m_y[0] + 3, 1, 4);
            drive_px(0, 0);
            for (int i = 0; i < 150; i++) begin
                int p, h, v;
                if (i == 75)
                    set_player(0, int'($urandom_range(0, 1300)), int'($urandom_range(0, 730)),
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                p = int'($urandom_range(0, NP - 1));
                h = (m_x[p] + int'($urandom_range(0, 40)) - 4) & 2047;
                v = (m_y[p] + int'($urandom_range(0, 40)) - 4) & 1023;
                if (h == 0 && v == 0) h = 1;
                drive_px(h, v);
            end
        end

        phase = "midreset";
        set_player(0, 100, 50, 3, 0);
        drive_px(0, 0);
        for (int h = 98; h <= 120; h++) drive_px(h, 51);
        #2;
        do_reset("midreset");
        first_frame_test();
        phase = "drain";
        for (int i = 0; i < 6; i++) drive_px(700, 700);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
